// File: rtl/monitor_pio_pkg.sv
// Shared constants for the monitor PIO input port: bus geometry, register
// offsets and edge-type selectors.
package monitor_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] OFF_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] OFF_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] OFF_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] OFF_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/monitor_sync_bus.sv
// Multi-flop synchroniser for a bus of independent asynchronous inputs;
// dout is din delayed by SYNC_STAGES clocks.
module monitor_sync_bus #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Element 0 is the first flop; the last element feeds the core logic.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/monitor_pio_in_edge.sv
// Avalon-MM general-purpose input port with synchronised level readback,
// sticky per-bit edge capture, interrupt mask and level interrupt.
module monitor_pio_in_edge
    import monitor_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned WARM_W   = $clog2(WARM_MAX + 1);

    logic [WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  irqmask_q;
    logic [WIDTH-1:0]  edgecap_q;
    logic [WARM_W-1:0] warm_cnt_q;

    logic              warm_done_c;
    logic              wr_en_c;
    logic [WIDTH-1:0]  edge_det_c;
    logic [WIDTH-1:0]  clr_c;
    logic [WIDTH-1:0]  edgecap_d_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic              unused_wdata;

    monitor_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (in_port),
        .dout  (sync_q)
    );

    // Warm-up keeps a level already present at reset from looking like an edge.
    assign warm_done_c = (warm_cnt_q == WARM_W'(WARM_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            warm_cnt_q <= '0;
        end else begin
            prev_q <= sync_q;
            if (!warm_done_c) begin
                warm_cnt_q <= warm_cnt_q + WARM_W'(1);
            end
        end
    end

    always_comb begin
        edge_det_c = '0;
        if (warm_done_c) begin
            case (EDGE_TYPE)
                EDGE_RISING:  edge_det_c = sync_q & ~prev_q;
                EDGE_FALLING: edge_det_c = ~sync_q & prev_q;
                default:      edge_det_c = sync_q ^ prev_q;
            endcase
        end
    end

    assign wr_en_c      = chipselect & ~write_n;
    assign clr_c        = (wr_en_c && address == OFF_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    // Clear first, then OR in new edges so a coincident edge survives the clear.
    assign edgecap_d_c  = (edgecap_q & ~clr_c) | edge_det_c;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            edgecap_q <= edgecap_d_c;
            if (wr_en_c && address == OFF_IRQMASK) begin
                irqmask_q <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_mux_c = '0;
        case (address)
            OFF_DATA:    rd_mux_c = DATA_W'(sync_q);
            OFF_IRQMASK: rd_mux_c = DATA_W'(irqmask_q);
            OFF_EDGECAP: rd_mux_c = DATA_W'(edgecap_q);
            default:     rd_mux_c = '0;
        endcase
    end

    // Read data tracks the address every cycle, independent of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux_c;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_monitor_pio_in_edge.sv
// Scoreboard bench: three port instances (rising/8b/2 stages, falling/8b/3
// stages, any-edge/5b/4 stages) share one bus and are checked every cycle.
module tb_monitor_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [7:0]  in0 = 8'hFF;
    logic [7:0]  in1 = 8'hFF;
    logic [4:0]  in2 = 5'h1F;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    monitor_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0));

    monitor_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(3)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irq1));

    monitor_pio_in_edge #(.WIDTH(5), .EDGE_TYPE(2), .SYNC_STAGES(4)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2));

    typedef struct packed {
        logic        is_irq;
        logic [1:0]  inst;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];

    // Reference model state: sampled input history per instance (ring),
    // edge count since reset release, sticky flags and mask.
    logic [31:0] samp_m [3][16];
    int          t_m    [3];
    logic [31:0] ecap_m [3];
    logic [31:0] mask_m [3];

    function automatic logic [31:0] p_wm(int i);
        return (i == 2) ? 32'h1F : 32'hFF;
    endfunction

    function automatic int p_s(int i);
        return i + 2;
    endfunction

    function automatic logic [31:0] p_in(int i);
        case (i)
            0:       return 32'(in0);
            1:       return 32'(in1);
            default: return 32'(in2);
        endcase
    endfunction

    function automatic logic [31:0] act_rd(int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    function automatic logic act_irq(int i);
        case (i)
            0:       return irq0;
            1:       return irq1;
            default: return irq2;
        endcase
    endfunction

    // Input value sampled at edge k after reset release (0 before edge 1).
    function automatic logic [31:0] lvl(int i, int k);
        if (k < 1) return 32'd0;
        return samp_m[i][k % 16];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: at each edge t, the synchronised level is the input sampled S
    // edges earlier, and its predecessor one edge before that.
    initial begin : model
        int t, s;
        logic [31:0] sy, pv, det, rexp, wm;
        logic wr;
        for (int i = 0; i < 3; i++) begin
            t_m[i] = 0; ecap_m[i] = 32'd0; mask_m[i] = 32'd0;
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < 3; i++) begin
                    t_m[i] = 0; ecap_m[i] = 32'd0; mask_m[i] = 32'd0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    t  = t_m[i] + 1;
                    s  = p_s(i);
                    wm = p_wm(i);
                    sy = lvl(i, t - s);
                    pv = lvl(i, t - s - 1);
                    case (address)
                        2'd0:    rexp = sy;
                        2'd2:    rexp = mask_m[i];
                        2'd3:    rexp = ecap_m[i];
                        default: rexp = 32'd0;
                    endcase
                    det = 32'd0;
                    if (t - 1 >= s + 1) begin
                        case (i)
                            0:       det = sy & ~pv;
                            1:       det = ~sy & pv;
                            default: det = sy ^ pv;
                        endcase
                    end
                    det = det & wm;
                    wr  = chipselect && !write_n;
                    if (wr && address == 2'd3) ecap_m[i] = ecap_m[i] & ~(writedata & wm);
                    ecap_m[i] = ecap_m[i] | det;
                    if (wr && address == 2'd2) mask_m[i] = writedata & wm;
                    sb.push_back({1'b0, 2'(i), rexp});
                    sb.push_back({1'b1, 2'(i), 32'(|(ecap_m[i] & mask_m[i]))});
                    samp_m[i][t % 16] = p_in(i) & wm;
                    t_m[i] = t;
                end
            end
        end
    end

    // Monitor: outputs are stable at the falling edge; pop and compare.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (e.is_irq) begin
                    if (act_irq(int'(e.inst)) !== e.exp[0]) begin
                        n_fail++;
                        $display("FAIL irq%0d @%0t: got %b, expected %b",
                                 e.inst, $time, act_irq(int'(e.inst)), e.exp[0]);
                    end
                end else if (act_rd(int'(e.inst)) !== e.exp) begin
                    n_fail++;
                    $display("FAIL readdata%0d @%0t: got %h, expected %h",
                             e.inst, $time, act_rd(int'(e.inst)), e.exp);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(logic [1:0] a, logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin : stim
        // Reset with inputs held high: nothing may be captured as an edge.
        cyc(3);
        chk("reset_rd0", rd0, 32'd0);
        chk("reset_rd2", rd2, 32'd0);
        chk("reset_irq", 32'({irq0, irq1, irq2}), 32'd0);
        reset = 1'b0;
        address = 2'd3;
        cyc(10);
        chk("warm_ecap0", rd0, 32'd0);
        chk("warm_ecap1", rd1, 32'd0);
        address = 2'd0;
        cyc(2);
        chk("warm_data0", rd0, 32'h0000_00FF);
        chk("warm_data2", rd2, 32'h0000_001F);

        // Rising capture 00 -> 05 with bit 2 unmasked, then clear bit 2.
        bus_wr(2'd2, 32'h04);
        in0 = 8'h00; in1 = 8'h00; in2 = 5'h00;
        cyc(8);
        bus_wr(2'd3, 32'hFF);
        address = 2'd3;
        cyc(2);
        in0 = 8'h05;
        cyc(8);
        chk("rise_ecap", rd0, 32'h05);
        chk("rise_irq", 32'(irq0), 32'd1);
        bus_wr(2'd3, 32'h04);
        cyc(3);
        chk("clr_ecap", rd0, 32'h01);
        chk("clr_irq", 32'(irq0), 32'd0);

        // Clear write lands on the same edge that sets bit 3.
        in0 = 8'h0D;
        cyc(2);
        address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h08;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1;
        cyc(1);
        chk("sticky_bit3", rd0 & 32'h08, 32'h08);

        // Single high pulse on bit 0 for the falling and any-edge builds.
        bus_wr(2'd3, 32'hFF);
        address = 2'd3;
        in1 = 8'h01; in2 = 5'h01;
        cyc(8);
        chk("fall_none", rd1, 32'h00);
        chk("any_rise", rd2, 32'h01);
        in1 = 8'h00; in2 = 5'h00;
        cyc(8);
        chk("fall_cap", rd1, 32'h01);
        chk("any_sticky", rd2, 32'h01);

        // Mask width, reserved offset and non-writes.
        bus_wr(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        cyc(2);
        chk("mask_w5", rd2, 32'h0000_001F);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        address = 2'd1;
        cyc(2);
        chk("rsvd", rd0, 32'd0);
        address = 2'd2; chipselect = 1'b1; write_n = 1'b1; writedata = 32'd0;
        cyc(2);
        chipselect = 1'b0; write_n = 1'b0;
        cyc(2);
        write_n = 1'b1;
        chk("nowrite_mask", rd0, 32'hFF);

        // Randomised traffic and input activity.
        for (int k = 0; k < 2000; k++) begin
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in0 = in0 ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 2) == 0) in1 = in1 ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 2) == 0) in2 = in2 ^ (5'($urandom) & 5'($urandom));
            cyc(1);
        end
        chipselect = 1'b0; write_n = 1'b1;

        // All flags set and unmasked, then asynchronous reset mid-cycle.
        bus_wr(2'd2, 32'hFF);
        in0 = 8'h00;
        cyc(6);
        bus_wr(2'd3, 32'hFF);
        address = 2'd3;
        in0 = 8'hFF;
        cyc(6);
        chk("pre_rst_ecap", rd0, 32'hFF);
        chk("pre_rst_irq", 32'(irq0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_irq", 32'({irq0, irq1, irq2}), 32'd0);
        chk("async_rd0", rd0, 32'd0);
        chk("async_rd1", rd1, 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(12);
        chk("rewarm_ecap0", rd0, 32'd0);
        address = 2'd0;
        cyc(4);
        chk("rewarm_data0", rd0, 32'hFF);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
